l2_line_writer: RTL and testbench
=================================

# l2_line_writer

Write-side companion to the L2 lookup logic. Takes a resolved update (set, way, per-word mask, new Spandex state, optional new tag), performs a read-modify-write of that way's per-word state row in the L2 tag/state SRAM, and commits the merged row. On line fills it also advances the set's eviction pointer. The L2 controller FSM issues an update after a lookup decides the outcome, and waits on `done_valid` before the next lookup to the same set.

## Interface
Parameters:
- `L2_WAYS`, 8: ways per set.
- `WORDS_PER_LINE`, 4: words per line; one state field per word.
- `L2_SET_BITS`, 9: set index width.
- `L2_TAG_BITS`, 18: tag width.
- `STATE_BITS`, 2: width of `state_t`.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: update request valid.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_set` in `L2_SET_BITS`: target set.
- `req_way` in `l2_way_t`: target way.
- `req_word_mask` in `WORDS_PER_LINE`: words whose state is replaced.
- `req_state` in `STATE_BITS`: new state for the masked words.
- `req_tag_en` in 1: line fill; write the tag and advance the evict pointer.
- `req_tag` in `L2_TAG_BITS`: tag written when `req_tag_en` is set.
- `rd_en` out 1: SRAM state-row read strobe.
- `rd_set` out `L2_SET_BITS`: set to read.
- `rd_way` out `l2_way_t`: way to read.
- `rd_states` in `WORDS_PER_LINE*STATE_BITS`: read data, valid one cycle after `rd_en`.
- `wr_en` out 1: SRAM write strobe.
- `wr_set` out `L2_SET_BITS`: set to write.
- `wr_way` out `l2_way_t`: way to write.
- `wr_states` out `WORDS_PER_LINE*STATE_BITS`: merged state row.
- `wr_tag_en` out 1: also write the tag.
- `wr_tag` out `L2_TAG_BITS`: tag to write.
- `evict_wr_en` out 1: write the set's evict pointer.
- `evict_wr_way` out `l2_way_t`: new evict pointer value.
- `done_valid` out 1: one-cycle completion pulse.
- `done_line_inv` out 1: qualified by `done_valid`; every word of the committed row is `SPX_I`.

## Operation
- **Acceptance:** a request is accepted when `req_valid && req_ready`. All `req_*` fields are captured into a request register; the inputs are not sampled again.
- **FSM states:** IDLE, READ, MERGE, WRITE.
- **IDLE:** on accept, go to WRITE if the mask is all-ones, otherwise go to READ. A full overwrite needs no old data.
- **READ:** assert `rd_en` with the captured set and way; go to MERGE.
- **MERGE:** for each word j, the merged row takes `req_state` where mask[j]=1, otherwise `rd_states[j]`. Register the result; go to WRITE.
- **Full-mask path:** the merged row is `req_state` replicated into every word.
- **WRITE:** assert `wr_en`, `wr_set`, `wr_way` and `wr_states`, plus `wr_tag_en`/`wr_tag` when the captured `req_tag_en` is set. In the same cycle assert `done_valid`, with `done_line_inv`=1 iff every merged word equals `SPX_I`. Then go to IDLE.
- **Evict pointer:** in WRITE with `req_tag_en`=1, assert `evict_wr_en` with `evict_wr_way` = (`req_way`+1) mod `L2_WAYS`. Wrap: way `L2_WAYS`-1 gives 0.
- **Empty mask:** still performs READ and WRITE, rewriting the unchanged row, and pulses done. Tag and evict are written if requested.
- **SRAM port:** single-ported. `rd_en` and `wr_en` are never high in the same cycle. The SRAM returns newly written data on a read issued the cycle after a write; back-to-back updates to the same way therefore merge correctly.

## Timing
- **Partial mask, accepted at cycle T:** `rd_en` at T+1, merge at T+2, `wr_en`/`done_valid` at T+3, `req_ready`=1 again at T+4.
- **Full mask, accepted at cycle T:** `wr_en`/`done_valid` at T+1, `req_ready`=1 at T+2.
- **Output decode:** all strobes are decoded from registered state and the request register; there are no combinational paths from `req_*` or `rd_states` to outputs.
- **Reset values:** FSM in IDLE. `req_ready`, `rd_en`, `wr_en`, `wr_tag_en`, `evict_wr_en`, `done_valid`, `done_line_inv` are all 0. Address, data and tag outputs are 0.
- **Ready after reset:** `req_ready` is forced 0 while `rst`=1 and rises the first cycle after `rst` falls.
- **Reset mid-operation:** an in-flight request is dropped. No `wr_en` or `done_valid` is issued for it. The SRAM row keeps its prior contents, provided the write cycle itself was not reached.
- **`req_valid` while busy:** ignored; the requester holds it until `req_ready`.

## Structure
- **Shared package:** `state_t`, the `SPX_*` state encodings (`SPX_I` = 0), `l2_way_t`, `l2_set_t`, `l2_tag_t` and `word_mask_t` belong in the shared Spandex types/constants package. Do not redefine them locally.
- **Sub-module:** one natural sub-module, `l2_state_merge`. It is purely combinational: masked per-word select plus the all-`SPX_I` detect.
- **Top level:** the FSM, the request register and output decode.

## Test plan
- **Partial merge:** SRAM row {R,S,I,V}, request mask 0b0101 with state `SPX_I` → `rd_en` at T+1, `wr_states`={I,S,I,V}, `done_valid` at T+3, `done_line_inv`=0.
- **Full-mask fill:** mask 0xF, state `SPX_S`, `req_tag_en`=1, tag 0x2A, way 7 → no `rd_en`. At T+1: `wr_states` all S, `wr_tag`=0x2A, `evict_wr_en`=1, `evict_wr_way`=0.
- **Full invalidation:** row {I,I,R,I}, mask 0b0100, state I → `done_line_inv`=1; `evict_wr_en` stays 0.
- **Back-to-back same way:** two partial updates to the same way, the second `req_valid` held from T → second accepted at T+4. Its read returns the first update's row; the final row reflects both masks.
- **Reset mid-operation:** assert `rst` during MERGE → no `wr_en` or `done_valid`, all outputs 0. `req_ready`=1 the cycle after `rst` deasserts.
- **Port exclusivity:** random request stream → `rd_en && wr_en` never observed high together.

Source files
------------

// File: rtl/l2_line_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_writer_pkg
// Description : Shared Spandex L2 types and constants: per-word coherence
//               state encodings, set/way/tag/mask types, the packed per-line
//               state row and the line-writer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_line_writer_pkg;

    // Default geometry of the L2 tag/state array
    localparam int L2_WAYS_DEF        = 8;
    localparam int WORDS_PER_LINE_DEF = 4;
    localparam int L2_SET_BITS_DEF    = 9;
    localparam int L2_TAG_BITS_DEF    = 18;
    localparam int STATE_BITS_DEF     = 2;
    localparam int L2_WAY_BITS_DEF    = $clog2(L2_WAYS_DEF);

    // Per-word Spandex coherence state
    typedef logic [STATE_BITS_DEF-1:0] state_t;

    localparam state_t SPX_I = 2'd0;  // invalid
    localparam state_t SPX_V = 2'd1;  // valid (self-invalidated)
    localparam state_t SPX_S = 2'd2;  // shared
    localparam state_t SPX_R = 2'd3;  // registered (owned)

    typedef logic [L2_WAY_BITS_DEF-1:0]                   l2_way_t;
    typedef logic [L2_SET_BITS_DEF-1:0]                   l2_set_t;
    typedef logic [L2_TAG_BITS_DEF-1:0]                   l2_tag_t;
    typedef logic [WORDS_PER_LINE_DEF-1:0]                word_mask_t;
    // Word j occupies bits [j*STATE_BITS +: STATE_BITS]
    typedef logic [WORDS_PER_LINE_DEF*STATE_BITS_DEF-1:0] state_row_t;

    // Line-writer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2,
        ST_WRITE = 2'd3
    } lw_fsm_t;

endpackage : l2_line_writer_pkg
`default_nettype wire

// File: rtl/l2_line_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_writer_if
// Description : Bundle between the L2 controller, the line writer and the
//               tag/state SRAM port.
//                 req_*      : update request (valid/ready handshake)
//                 rd_*       : state-row read strobe, address and read data
//                 wr_*       : state-row / tag write strobe, address and data
//                 evict_wr_* : per-set eviction pointer write
//                 done_*     : completion pulse and all-invalid flag
//               slave  : the line writer
//               master : the controller + SRAM side
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_line_writer_if;
    import l2_line_writer_pkg::*;

    logic       req_valid;
    logic       req_ready;
    l2_set_t    req_set;
    l2_way_t    req_way;
    word_mask_t req_word_mask;
    state_t     req_state;
    logic       req_tag_en;
    l2_tag_t    req_tag;

    logic       rd_en;
    l2_set_t    rd_set;
    l2_way_t    rd_way;
    state_row_t rd_states;

    logic       wr_en;
    l2_set_t    wr_set;
    l2_way_t    wr_way;
    state_row_t wr_states;
    logic       wr_tag_en;
    l2_tag_t    wr_tag;

    logic       evict_wr_en;
    l2_way_t    evict_wr_way;

    logic       done_valid;
    logic       done_line_inv;

    modport slave (
        input  req_valid, req_set, req_way, req_word_mask, req_state,
               req_tag_en, req_tag, rd_states,
        output req_ready, rd_en, rd_set, rd_way, wr_en, wr_set, wr_way,
               wr_states, wr_tag_en, wr_tag, evict_wr_en, evict_wr_way,
               done_valid, done_line_inv
    );

    modport master (
        output req_valid, req_set, req_way, req_word_mask, req_state,
               req_tag_en, req_tag, rd_states,
        input  req_ready, rd_en, rd_set, rd_way, wr_en, wr_set, wr_way,
               wr_states, wr_tag_en, wr_tag, evict_wr_en, evict_wr_way,
               done_valid, done_line_inv
    );

endinterface : l2_line_writer_if
`default_nettype wire

// File: rtl/l2_state_merge.sv
`default_nettype none
// ============================================================================
// Module      : l2_state_merge
// Description : Combinational per-word state merge. Each word takes the new
//               state where its mask bit is set, otherwise keeps the old
//               state. Also flags a merged row whose every word is SPX_I.
// Ports       : i_old_row  - current state row (word j at [j*SB +: SB])
//               i_mask     - words to replace
//               i_state    - replacement state
//               o_row      - merged row
//               o_all_inv  - every merged word equals SPX_I
// Revision    : 1.0 - initial release
// ============================================================================
module l2_state_merge
    import l2_line_writer_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int STATE_BITS     = STATE_BITS_DEF
) (
    input  wire logic [WORDS_PER_LINE*STATE_BITS-1:0] i_old_row,
    input  wire logic [WORDS_PER_LINE-1:0]            i_mask,
    input  wire logic [STATE_BITS-1:0]                i_state,
    output logic      [WORDS_PER_LINE*STATE_BITS-1:0] o_row,
    output logic                                      o_all_inv
);

    logic [WORDS_PER_LINE-1:0] w_word_inv;

    generate
        for (genvar j = 0; j < WORDS_PER_LINE; j++) begin : g_word
            assign o_row[j*STATE_BITS +: STATE_BITS] =
                i_mask[j] ? i_state : i_old_row[j*STATE_BITS +: STATE_BITS];
            assign w_word_inv[j] =
                (o_row[j*STATE_BITS +: STATE_BITS] == STATE_BITS'(SPX_I));
        end
    endgenerate

    assign o_all_inv = &w_word_inv;

endmodule : l2_state_merge
`default_nettype wire

// File: rtl/l2_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_writer
// Description : Read-modify-write of one way's per-word Spandex state row in
//               the L2 tag/state SRAM. A partial mask reads the old row,
//               merges and writes it back (accept T: read T+1, merge T+2,
//               write + done T+3). A full mask skips the read (write + done
//               T+1). Line fills (req_tag_en) also write the tag and advance
//               the set's eviction pointer to the following way.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - request / SRAM / completion bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_writer
    import l2_line_writer_pkg::*;
#(
    parameter int L2_WAYS        = L2_WAYS_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int L2_SET_BITS    = L2_SET_BITS_DEF,
    parameter int L2_TAG_BITS    = L2_TAG_BITS_DEF,
    parameter int STATE_BITS     = STATE_BITS_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    l2_line_writer_if.slave   bus
);

    localparam int      c_ROW_BITS = WORDS_PER_LINE * STATE_BITS;
    localparam l2_way_t c_LAST_WAY = l2_way_t'(L2_WAYS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    lw_fsm_t                    r_state;
    logic                       r_ready;

    // Request register: captured once at accept, never resampled
    logic [L2_SET_BITS-1:0]     r_set;
    l2_way_t                    r_way;
    logic [WORDS_PER_LINE-1:0]  r_mask;
    logic [STATE_BITS-1:0]      r_new_state;
    logic                       r_tag_en;
    logic [L2_TAG_BITS-1:0]     r_tag;
    l2_way_t                    r_evict_way;

    // Registered strobes and merged row
    logic                       r_rd_en;
    logic                       r_wr_en;
    logic                       r_wr_tag_en;
    logic                       r_evict_wr_en;
    logic                       r_done;
    logic                       r_done_inv;
    logic [c_ROW_BITS-1:0]      r_row;

    // ------------------------------------------------------------------
    // Merge operand selection
    // In IDLE the merger sees the incoming request so a full-mask update
    // can be committed straight from the accept edge; the old row is a
    // don't-care there because every word is replaced. In MERGE it sees
    // the captured request and the SRAM read data.
    // ------------------------------------------------------------------
    logic [c_ROW_BITS-1:0]      w_mrg_old;
    logic [WORDS_PER_LINE-1:0]  w_mrg_mask;
    logic [STATE_BITS-1:0]      w_mrg_state;
    logic [c_ROW_BITS-1:0]      w_mrg_row;
    logic                       w_mrg_inv;
    logic                       w_accept;
    logic                       w_full_mask;
    l2_way_t                    w_next_way;

    always_comb begin
        w_mrg_old   = '0;
        w_mrg_mask  = r_mask;
        w_mrg_state = r_new_state;
        if (r_state == ST_IDLE) begin
            w_mrg_mask  = bus.req_word_mask;
            w_mrg_state = bus.req_state;
        end else if (r_state == ST_MERGE) begin
            w_mrg_old   = bus.rd_states;
        end
    end

    l2_state_merge #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .STATE_BITS     (STATE_BITS)
    ) u_merge (
        .i_old_row (w_mrg_old),
        .i_mask    (w_mrg_mask),
        .i_state   (w_mrg_state),
        .o_row     (w_mrg_row),
        .o_all_inv (w_mrg_inv)
    );

    assign w_accept    = bus.req_valid && r_ready;
    assign w_full_mask = &bus.req_word_mask;
    // Eviction pointer moves to the way after the filled one, wrapping
    assign w_next_way  = (bus.req_way == c_LAST_WAY) ? '0
                                                     : bus.req_way + l2_way_t'(1);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ready       <= 1'b0;
            r_set         <= '0;
            r_way         <= '0;
            r_mask        <= '0;
            r_new_state   <= '0;
            r_tag_en      <= 1'b0;
            r_tag         <= '0;
            r_evict_way   <= '0;
            r_rd_en       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_tag_en   <= 1'b0;
            r_evict_wr_en <= 1'b0;
            r_done        <= 1'b0;
            r_done_inv    <= 1'b0;
            r_row         <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_rd_en       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_tag_en   <= 1'b0;
            r_evict_wr_en <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready     <= 1'b0;
                        r_set       <= bus.req_set;
                        r_way       <= bus.req_way;
                        r_mask      <= bus.req_word_mask;
                        r_new_state <= bus.req_state;
                        r_tag_en    <= bus.req_tag_en;
                        r_tag       <= bus.req_tag;
                        r_evict_way <= w_next_way;
                        if (w_full_mask) begin
                            // Full overwrite: no old data needed
                            r_state       <= ST_WRITE;
                            r_row         <= w_mrg_row;
                            r_done_inv    <= w_mrg_inv;
                            r_wr_en       <= 1'b1;
                            r_done        <= 1'b1;
                            r_wr_tag_en   <= bus.req_tag_en;
                            r_evict_wr_en <= bus.req_tag_en;
                        end else begin
                            r_state <= ST_READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    // SRAM data arrives during MERGE
                    r_state <= ST_MERGE;
                end

                ST_MERGE: begin
                    r_state       <= ST_WRITE;
                    r_row         <= w_mrg_row;
                    r_done_inv    <= w_mrg_inv;
                    r_wr_en       <= 1'b1;
                    r_done        <= 1'b1;
                    r_wr_tag_en   <= r_tag_en;
                    r_evict_wr_en <= r_tag_en;
                end

                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state and request register only)
    // ------------------------------------------------------------------
    assign bus.req_ready     = r_ready;
    assign bus.rd_en         = r_rd_en;
    assign bus.rd_set        = r_set;
    assign bus.rd_way        = r_way;
    assign bus.wr_en         = r_wr_en;
    assign bus.wr_set        = r_set;
    assign bus.wr_way        = r_way;
    assign bus.wr_states     = r_row;
    assign bus.wr_tag_en     = r_wr_tag_en;
    assign bus.wr_tag        = r_tag;
    assign bus.evict_wr_en   = r_evict_wr_en;
    assign bus.evict_wr_way  = r_evict_way;
    assign bus.done_valid    = r_done;
    assign bus.done_line_inv = r_done_inv;

endmodule : l2_line_writer
`default_nettype wire

// File: tb/tb_l2_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_line_writer
// Description : Self-checking bench for l2_line_writer: directed vector
//               table, back-to-back and mid-operation reset sequences, and a
//               random request stream checked against a shadow-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_line_writer;
    import l2_line_writer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_line_writer_if bus ();

    l2_line_writer #(
        .L2_WAYS        (8),
        .WORDS_PER_LINE (4),
        .L2_SET_BITS    (9),
        .L2_TAG_BITS    (18),
        .STATE_BITS     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // SRAM model: one-cycle read latency, write visible to next read
    // ------------------------------------------------------------------
    logic [7:0] mem    [0:511][0:7];
    logic [7:0] shadow [0:511][0:7];
    logic       pl_en;
    logic [8:0] pl_set;
    logic [2:0] pl_way;
    logic [7:0] pl_data;
    int         excl_viol = 0;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_states <= mem[bus.rd_set][bus.rd_way];
        if (bus.wr_en) mem[bus.wr_set][bus.wr_way] <= bus.wr_states;
        if (pl_en)     mem[pl_set][pl_way] <= pl_data;
    end

    always @(negedge clk) begin
        if (bus.rd_en && bus.wr_en) excl_viol++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    typedef struct {
        logic [8:0]  set;
        logic [2:0]  way;
        logic [3:0]  mask;
        logic [1:0]  st;
        logic        tag_en;
        logic [17:0] tag;
        logic [7:0]  init;
        logic [7:0]  exp_row;
        logic        exp_inv;
        logic        exp_full;
        logic [2:0]  exp_ev_way;
    } vec_t;

    // Reference merge: word j lives at bits [2j+1:2j]
    function automatic logic [7:0] model_merge(input logic [7:0] old, input logic [3:0] mask,
                                               input logic [1:0] st);
        logic [7:0] r;
        r = old;
        for (int j = 0; j < 4; j++)
            if (mask[j]) r[j*2 +: 2] = st;
        return r;
    endfunction

    function automatic logic outs_or();
        return |{bus.req_ready, bus.rd_en, bus.wr_en, bus.wr_tag_en, bus.evict_wr_en,
                 bus.done_valid, bus.done_line_inv, bus.rd_set, bus.rd_way, bus.wr_set,
                 bus.wr_way, bus.wr_states, bus.wr_tag, bus.evict_wr_way};
    endfunction

    task automatic preload(input logic [8:0] s, input logic [2:0] w, input logic [7:0] d);
        pl_set = s; pl_way = w; pl_data = d; pl_en = 1'b1;
        shadow[s][w] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // Captured transaction observations
    int          cap_done, cap_rd;
    logic [8:0]  cap_rd_set, cap_wr_set;
    logic [2:0]  cap_rd_way, cap_wr_way, cap_ev_way;
    logic [7:0]  cap_row;
    logic [17:0] cap_tag;
    logic        cap_inv, cap_tag_en, cap_ev_en, cap_wr_en;
    logic        cap_ready_at_done, cap_ready_after, cap_done_after;

    task automatic drive_req(input vec_t v);
        wait_ready();
        bus.req_set = v.set; bus.req_way = v.way; bus.req_word_mask = v.mask;
        bus.req_state = v.st; bus.req_tag_en = v.tag_en; bus.req_tag = v.tag;
        bus.req_valid = 1'b1;
        @(posedge clk);
    endtask

    // Called just after the accept edge; k counts cycles after acceptance
    task automatic observe();
        cap_done = -1; cap_rd = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs: the captured request must be used
                bus.req_valid = 1'b0;
                bus.req_set = 9'($urandom); bus.req_way = 3'($urandom);
                bus.req_word_mask = 4'($urandom); bus.req_state = 2'($urandom);
                bus.req_tag_en = 1'($urandom); bus.req_tag = 18'($urandom);
            end
            if (bus.rd_en && cap_rd < 0) begin
                cap_rd = k; cap_rd_set = bus.rd_set; cap_rd_way = bus.rd_way;
            end
            if (bus.done_valid) begin
                cap_done = k; cap_wr_en = bus.wr_en; cap_wr_set = bus.wr_set;
                cap_wr_way = bus.wr_way; cap_row = bus.wr_states; cap_inv = bus.done_line_inv;
                cap_tag_en = bus.wr_tag_en; cap_tag = bus.wr_tag; cap_ev_en = bus.evict_wr_en;
                cap_ev_way = bus.evict_wr_way; cap_ready_at_done = bus.req_ready;
                break;
            end
        end
        @(negedge clk);
        cap_ready_after = bus.req_ready;
        cap_done_after  = bus.done_valid;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        drive_req(v);
        observe();
        check({nm, "_done_lat"}, cap_done, v.exp_full ? 32'd1 : 32'd3);
        check({nm, "_rd_lat"}, cap_rd, v.exp_full ? 32'hFFFF_FFFF : 32'd1);
        if (!v.exp_full) check({nm, "_rd_addr"}, 32'({cap_rd_set, cap_rd_way}), 32'({v.set, v.way}));
        check({nm, "_wr_en"}, 32'(cap_wr_en), 32'd1);
        check({nm, "_wr_addr"}, 32'({cap_wr_set, cap_wr_way}), 32'({v.set, v.way}));
        check({nm, "_wr_states"}, 32'(cap_row), 32'(v.exp_row));
        check({nm, "_line_inv"}, 32'(cap_inv), 32'(v.exp_inv));
        check({nm, "_tag_en"}, 32'(cap_tag_en), 32'(v.tag_en));
        check({nm, "_evict_en"}, 32'(cap_ev_en), 32'(v.tag_en));
        if (v.tag_en) begin
            check({nm, "_tag"}, 32'(cap_tag), 32'(v.tag));
            check({nm, "_evict_way"}, 32'(cap_ev_way), 32'(v.exp_ev_way));
        end
        check({nm, "_busy_at_done"}, 32'(cap_ready_at_done), 32'd0);
        check({nm, "_ready_after"}, 32'(cap_ready_after), 32'd1);
        check({nm, "_done_pulse"}, 32'(cap_done_after), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        int a_done, b_acc, b_rd, b_done, seen, bad;
        logic [7:0] a_row, b_rdata, b_row;
        vec_t v;

        // set  way  mask  state tag_en tag  init   exp   inv full ev_way
        vecs[0] = '{9'd5,   3'd2, 4'b0101, SPX_I, 1'b0, 18'h0,     8'h4B, 8'h48, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{9'd17,  3'd7, 4'b1111, SPX_S, 1'b1, 18'h2A,    8'h1B, 8'hAA, 1'b0, 1'b1, 3'd0};
        vecs[2] = '{9'd100, 3'd1, 4'b0100, SPX_I, 1'b0, 18'h0,     8'h30, 8'h00, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{9'd200, 3'd3, 4'b0000, SPX_R, 1'b1, 18'h3FFFF, 8'hE4, 8'hE4, 1'b0, 1'b0, 3'd4};
        vecs[4] = '{9'd0,   3'd0, 4'b1111, SPX_I, 1'b0, 18'h0,     8'h5A, 8'h00, 1'b1, 1'b1, 3'd0};
        vecs[5] = '{9'd511, 3'd5, 4'b1000, SPX_R, 1'b1, 18'h12345, 8'h00, 8'hC0, 1'b0, 1'b0, 3'd6};

        rst = 1'b1; pl_en = 1'b0; pl_set = '0; pl_way = '0; pl_data = '0;
        bus.req_valid = 1'b0; bus.req_set = '0; bus.req_way = '0; bus.req_word_mask = '0;
        bus.req_state = '0; bus.req_tag_en = 1'b0; bus.req_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_outputs", 32'(outs_or()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].set, vecs[i].way, vecs[i].init);
            run_vec($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("vec%0d_sram", i), 32'(mem[vecs[i].set][vecs[i].way]),
                  32'(vecs[i].exp_row));
        end

        // Back-to-back partial updates to the same way, second valid held
        preload(9'd9, 3'd4, 8'h1B);
        wait_ready();
        bus.req_set = 9'd9; bus.req_way = 3'd4; bus.req_word_mask = 4'b0011;
        bus.req_state = SPX_V; bus.req_tag_en = 1'b0; bus.req_tag = '0; bus.req_valid = 1'b1;
        @(posedge clk);
        a_done = -1; b_acc = -1; b_rd = -1; b_done = -1;
        a_row = '0; b_rdata = '0; b_row = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_word_mask = 4'b0110; bus.req_state = SPX_I;
            end
            if (b_acc > 0 && k == b_acc + 1) bus.req_valid = 1'b0;
            if (bus.done_valid && a_done < 0) begin
                a_done = k; a_row = bus.wr_states;
            end
            if (bus.req_ready && bus.req_valid && b_acc < 0) b_acc = k;
            if (b_acc > 0 && k > b_acc && bus.rd_en && b_rd < 0) b_rd = k;
            if (b_rd > 0 && k == b_rd + 1) b_rdata = bus.rd_states;
            if (b_acc > 0 && k > b_acc && bus.done_valid) begin
                b_done = k; b_row = bus.wr_states;
                break;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_first_done", a_done, 32'd3);
        check("b2b_first_row", 32'(a_row), 32'h15);
        check("b2b_second_accept", b_acc, 32'd4);
        check("b2b_second_rd", b_rd, 32'd5);
        check("b2b_second_rdata", 32'(b_rdata), 32'h15);
        check("b2b_second_done", b_done, 32'd7);
        check("b2b_second_row", 32'(b_row), 32'h01);
        check("b2b_sram", 32'(mem[9][4]), 32'h01);

        // Reset during MERGE
        preload(9'd33, 3'd6, 8'h9C);
        v = '{9'd33, 3'd6, 4'b0001, SPX_S, 1'b1, 18'h777, 8'h9C, 8'h9E, 1'b0, 1'b0, 3'd7};
        drive_req(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (bus.wr_en || bus.done_valid) seen++;
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_outputs", 32'(outs_or()), 32'd0);
        @(negedge clk);
        if (bus.wr_en || bus.done_valid) seen++;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (bus.wr_en || bus.done_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_write", seen, 32'd0);
        check("midrst_sram_kept", 32'(mem[33][6]), 32'h9C);

        // Random stream against the shadow-memory model
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 8; w++)
                preload(9'(s), 3'(w), 8'($urandom));
        for (int n = 0; n < 150; n++) begin
            v.set        = 9'($urandom_range(0, 3));
            v.way        = 3'($urandom);
            v.mask       = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            v.st         = 2'($urandom);
            v.tag_en     = 1'($urandom);
            v.tag        = 18'($urandom);
            v.init       = shadow[v.set][v.way];
            v.exp_row    = model_merge(v.init, v.mask, v.st);
            v.exp_inv    = (v.exp_row == 8'h00);
            v.exp_full   = (v.mask == 4'hF);
            v.exp_ev_way = 3'((int'(v.way) + 1) % 8);
            run_vec("rnd", v);
            shadow[v.set][v.way] = v.exp_row;
        end
        bad = 0;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 8; w++)
                if (mem[s][w] !== shadow[s][w]) bad++;
        check("final_sram", bad, 32'd0);
        check("port_exclusive", excl_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_l2_line_writer
`default_nettype wire
